// File: rtl/general_register.sv
// WIDTH-bit function-select register with byte-lane writes, shifts/rotates and a serial shift engine.
// Optional macro GENERAL_REGISTER_SAT_EN makes increment/decrement saturate instead of wrap.
module general_register #(
  parameter  int WIDTH = 16,
  localparam int LANES = WIDTH / 8,
  localparam int BSW   = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int SAW   = $clog2(WIDTH) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic             E,
  input  logic [3:0]       FunSel,
  input  logic [BSW-1:0]   ByteSel,
  input  logic [SAW-1:0]   ShAmt,
  output logic [WIDTH-1:0] Q,
  output logic             Z,
  output logic             C,
  output logic             Busy,
  output logic             Done
);

  localparam logic [0:0]       IDLE  = 1'b0;
  localparam logic [0:0]       SHIFT = 1'b1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [0:0]       state_q, state_d;
  logic [SAW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             c_q, c_d;
  logic             done_q, done_d;

  // Return {carry, result}; the carry flags the all-ones wrap case.
  function automatic logic [WIDTH:0] inc_f(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v + ONE;
`ifdef GENERAL_REGISTER_SAT_EN
    if (v == '1) r = v;
`endif
    return {(v == '1), r};
  endfunction

  function automatic logic [WIDTH:0] dec_f(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v - ONE;
`ifdef GENERAL_REGISTER_SAT_EN
    if (v == '0) r = v;
`endif
    return {(v == '0), r};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    q_d     = q_q;
    c_d     = c_q;
    done_d  = 1'b0;
    if (state_q == SHIFT) begin
      // dir_q = 1 means shift right
      if (dir_q) begin
        c_d = q_q[0];
        q_d = {1'b0, q_q[WIDTH-1:1]};
      end else begin
        c_d = q_q[WIDTH-1];
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - SAW'(1);
      if (cnt_q == SAW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (E) begin
      case (FunSel)
        4'b0000: {c_d, q_d} = dec_f(q_q);
        4'b0001: {c_d, q_d} = inc_f(q_q);
        4'b0010: q_d = I;
        4'b0011: begin
          q_d = '0;
          c_d = 1'b0;
        end
        4'b0100: q_d = {{(WIDTH-8){1'b0}}, I[7:0]};
        4'b0101: begin
          for (int l = 0; l < LANES; l++) begin
            if (int'(ByteSel) == l) q_d[l*8 +: 8] = I[7:0];
          end
        end
        4'b0110: q_d = {{(WIDTH-8){I[7]}}, I[7:0]};
        4'b1000: begin
          c_d = q_q[WIDTH-1];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        4'b1001: begin
          c_d = q_q[0];
          q_d = {1'b0, q_q[WIDTH-1:1]};
        end
        4'b1010: begin
          c_d = q_q[0];
          q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        end
        4'b1011: begin
          c_d = q_q[WIDTH-1];
          q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        end
        4'b1100: begin
          c_d = q_q[0];
          q_d = {q_q[0], q_q[WIDTH-1:1]};
        end
        4'b1101, 4'b1110: begin
          dir_d = FunSel[1];
          cnt_d = (ShAmt > SAW'(WIDTH)) ? SAW'(WIDTH) : ShAmt;
          if (cnt_d == '0) done_d  = 1'b1;
          else             state_d = SHIFT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      q_q     <= '0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      q_q     <= q_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign Z    = (q_q == '0);
  assign C    = c_q;
  assign Busy = (state_q == SHIFT);
  assign Done = done_q;

endmodule

// File: tb/tb_general_register.sv
// Directed bench for general_register: vector table on a 16-bit instance plus serial-shift,
// reset and 32-bit lane sequences.
module tb_general_register;

  logic        Clock;
  logic        Reset;
  logic [15:0] I;
  logic        E;
  logic [3:0]  FunSel;
  logic        ByteSel;
  logic [4:0]  ShAmt;
  logic [15:0] Q;
  logic        Z, C, Busy, Done;

  logic [31:0] I2;
  logic        E2;
  logic [3:0]  FunSel2;
  logic [1:0]  ByteSel2;
  logic [5:0]  ShAmt2;
  logic [31:0] Q2;
  logic        Z2, C2, Busy2, Done2;

  int checks = 0;
  int errors = 0;

  general_register #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .E(E), .FunSel(FunSel), .ByteSel(ByteSel),
    .ShAmt(ShAmt), .Q(Q), .Z(Z), .C(C), .Busy(Busy), .Done(Done)
  );

  general_register #(.WIDTH(32)) dut32 (
    .Clock(Clock), .Reset(Reset), .I(I2), .E(E2), .FunSel(FunSel2), .ByteSel(ByteSel2),
    .ShAmt(ShAmt2), .Q(Q2), .Z(Z2), .C(C2), .Busy(Busy2), .Done(Done2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        e;
    logic [3:0]  fun;
    logic [15:0] i;
    logic        bsel;
    logic [15:0] q0;
    logic        c0;
    logic [15:0] eq;
    logic        ec;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic op(input logic e, input logic [3:0] f, input logic [15:0] i,
                    input logic b, input logic [4:0] sh);
    @(negedge Clock);
    E = e; FunSel = f; I = i; ByteSel = b; ShAmt = sh;
    @(posedge Clock);
    #1;
    E = 1'b0;
  endtask

  task automatic op32(input logic [3:0] f, input logic [31:0] i, input logic [1:0] b);
    @(negedge Clock);
    E2 = 1'b1; FunSel2 = f; I2 = i; ByteSel2 = b; ShAmt2 = '0;
    @(posedge Clock);
    #1;
    E2 = 1'b0;
  endtask

  // C=1 is reached by incrementing all-ones, which sets the carry in both build modes.
  task automatic set_state(input logic [15:0] q, input logic c);
    if (c) begin
      op(1'b1, 4'b0010, 16'hFFFF, 1'b0, 5'd0);
      op(1'b1, 4'b0001, 16'h0000, 1'b0, 5'd0);
    end else begin
      op(1'b1, 4'b0011, 16'h0000, 1'b0, 5'd0);
    end
    op(1'b1, 4'b0010, q, 1'b0, 5'd0);
  endtask

  initial begin
    int n;
    Reset = 1'b0; E = 1'b0; FunSel = '0; I = '0; ByteSel = '0; ShAmt = '0;
    E2 = 1'b0; FunSel2 = '0; I2 = '0; ByteSel2 = '0; ShAmt2 = '0;

    vt[0]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0005, 1'b1, 16'h0004, 1'b0};
`ifdef GENERAL_REGISTER_SAT_EN
    vt[1]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
    vt[3]  = '{1'b1, 4'b0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1};
`else
    vt[1]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1};
    vt[3]  = '{1'b1, 4'b0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b1};
`endif
    vt[2]  = '{1'b1, 4'b0001, 16'h0000, 1'b0, 16'h00FF, 1'b1, 16'h0100, 1'b0};
    vt[4]  = '{1'b1, 4'b0010, 16'hABCD, 1'b0, 16'h1234, 1'b1, 16'hABCD, 1'b1};
    vt[5]  = '{1'b1, 4'b0011, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h0000, 1'b0};
    vt[6]  = '{1'b1, 4'b0100, 16'h12C5, 1'b0, 16'hFFFF, 1'b0, 16'h00C5, 1'b0};
    vt[7]  = '{1'b1, 4'b0101, 16'h00AB, 1'b1, 16'h1234, 1'b1, 16'hAB34, 1'b1};
    vt[8]  = '{1'b1, 4'b0101, 16'h55FF, 1'b0, 16'h1234, 1'b0, 16'h12FF, 1'b0};
    vt[9]  = '{1'b1, 4'b0110, 16'h0080, 1'b0, 16'h0000, 1'b0, 16'hFF80, 1'b0};
    vt[10] = '{1'b1, 4'b0110, 16'h117F, 1'b0, 16'hFFFF, 1'b1, 16'h007F, 1'b1};
    vt[11] = '{1'b1, 4'b0111, 16'hFFFF, 1'b0, 16'h5A5A, 1'b1, 16'h5A5A, 1'b1};
    vt[12] = '{1'b1, 4'b1000, 16'h0000, 1'b0, 16'h8001, 1'b0, 16'h0002, 1'b1};
    vt[13] = '{1'b1, 4'b1001, 16'h0000, 1'b0, 16'h8001, 1'b0, 16'h4000, 1'b1};
    vt[14] = '{1'b1, 4'b1010, 16'h0000, 1'b0, 16'h8002, 1'b1, 16'hC001, 1'b0};
    vt[15] = '{1'b1, 4'b1011, 16'h0000, 1'b0, 16'h8001, 1'b0, 16'h0003, 1'b1};
    vt[16] = '{1'b1, 4'b1100, 16'h0000, 1'b0, 16'h8001, 1'b0, 16'hC000, 1'b1};
    vt[17] = '{1'b1, 4'b1111, 16'hFFFF, 1'b0, 16'h00FF, 1'b1, 16'h00FF, 1'b1};
    vt[18] = '{1'b0, 4'b0010, 16'hFFFF, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0};

    repeat (2) @(posedge Clock);
    #1;
    check("reset_Q", 32'(Q), 32'h0);
    check("reset_Z", 32'(Z), 32'h1);
    check("reset_C", 32'(C), 32'h0);
    check("reset_Busy", 32'(Busy), 32'h0);
    check("reset_Done", 32'(Done), 32'h0);
    @(negedge Clock);
    Reset = 1'b1;

    for (int k = 0; k < 19; k++) begin
      set_state(vt[k].q0, vt[k].c0);
      op(vt[k].e, vt[k].fun, vt[k].i, vt[k].bsel, 5'd0);
      check($sformatf("vec%0d_Q", k), 32'(Q), 32'(vt[k].eq));
      check($sformatf("vec%0d_C", k), 32'(C), 32'(vt[k].ec));
      check($sformatf("vec%0d_Z", k), 32'(Z), 32'(vt[k].eq == 16'h0));
    end

    // ROL then ASR back-to-back
    set_state(16'h8001, 1'b0);
    op(1'b1, 4'b1011, 16'h0, 1'b0, 5'd0);
    check("rol_Q", 32'(Q), 32'h0003);
    check("rol_C", 32'(C), 32'h1);
    op(1'b1, 4'b1010, 16'h0, 1'b0, 5'd0);
    check("asr_Q", 32'(Q), 32'h0001);
    check("asr_C", 32'(C), 32'h1);

    // Serial LSL by 4 with a clear request held during Busy
    set_state(16'h0F0F, 1'b1);
    op(1'b1, 4'b1101, 16'h0, 1'b0, 5'd4);
    check("sl4_busy_t0", 32'(Busy), 32'h1);
    check("sl4_done_t0", 32'(Done), 32'h0);
    @(negedge Clock);
    E = 1'b1; FunSel = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clock);
      #1;
      check($sformatf("sl4_busy_t%0d", k), 32'(Busy), 32'h1);
      check($sformatf("sl4_done_t%0d", k), 32'(Done), 32'h0);
    end
    @(posedge Clock);
    #1;
    E = 1'b0;
    check("sl4_busy_t4", 32'(Busy), 32'h0);
    check("sl4_done_t4", 32'(Done), 32'h1);
    check("sl4_Q", 32'(Q), 32'hF0F0);
    check("sl4_C", 32'(C), 32'h0);
    @(posedge Clock);
    #1;
    check("sl4_done_t5", 32'(Done), 32'h0);
    check("sl4_Q_hold", 32'(Q), 32'hF0F0);

    // Serial LSR by 0
    set_state(16'hABCD, 1'b1);
    op(1'b1, 4'b1110, 16'h0, 1'b0, 5'd0);
    check("sr0_done", 32'(Done), 32'h1);
    check("sr0_busy", 32'(Busy), 32'h0);
    check("sr0_Q", 32'(Q), 32'hABCD);
    check("sr0_C", 32'(C), 32'h1);
    @(posedge Clock);
    #1;
    check("sr0_done_clr", 32'(Done), 32'h0);
    check("sr0_busy_clr", 32'(Busy), 32'h0);

    // Serial LSR by 17 saturates to 16 shifts
    set_state(16'h8000, 1'b0);
    op(1'b1, 4'b1110, 16'h0, 1'b0, 5'd17);
    n = 0;
    while (!Done && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
    end
    check("sr17_edges", 32'(n), 32'd16);
    check("sr17_Q", 32'(Q), 32'h0);
    check("sr17_C", 32'(C), 32'h1);
    check("sr17_Z", 32'(Z), 32'h1);

    // Asynchronous reset mid-shift
    set_state(16'h00F0, 1'b1);
    op(1'b1, 4'b1101, 16'h0, 1'b0, 5'd4);
    repeat (2) @(posedge Clock);
    #1;
    check("mid_Q_before", 32'(Q), 32'h03C0);
    check("mid_busy_before", 32'(Busy), 32'h1);
    #2;
    Reset = 1'b0;
    #1;
    check("mid_rst_Q", 32'(Q), 32'h0);
    check("mid_rst_C", 32'(C), 32'h0);
    check("mid_rst_Busy", 32'(Busy), 32'h0);
    check("mid_rst_Done", 32'(Done), 32'h0);
    check("mid_rst_Z", 32'(Z), 32'h1);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("post_rst_busy", 32'(Busy), 32'h0);
    check("post_rst_Q", 32'(Q), 32'h0);

    // 32-bit lane write and sign extension
    op32(4'b0010, 32'h11223344, 2'd0);
    check("w32_load", Q2, 32'h11223344);
    op32(4'b0101, 32'h000000AB, 2'd2);
    check("w32_lane2", Q2, 32'h11AB3344);
    op32(4'b0101, 32'hFFFFFF01, 2'd3);
    check("w32_lane3", Q2, 32'h01AB3344);
    op32(4'b0110, 32'h00000080, 2'd0);
    check("w32_sext", Q2, 32'hFFFFFF80);
    check("w32_C", 32'(C2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/general_register.md
# general_register

Parametrised successor of the datapath's 16-bit function-select register. It is a WIDTH-bit register with the existing load/increment/decrement/byte-load modes, plus arbitrary byte-lane writes, single-bit shifts and rotates, and a multi-cycle serial shift engine with a Busy/Done handshake. It also exports zero and carry flags. It drops into the ALU system wherever a plain register was used, and feeds the flag logic directly.

## Interface
- WIDTH, 16, register width in bits; multiple of 8, at least 16.
- LANES, WIDTH/8, derived byte-lane count; not to be overridden.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- I  in  WIDTH  data input.
- E  in  1  enable; a FunSel operation is accepted only on an edge with E=1 and Busy=0.
- FunSel  in  4  operation select.
- ByteSel  in  max(1,$clog2(LANES))  target lane for the lane write.
- ShAmt  in  $clog2(WIDTH)+1  serial shift amount.
- Q  out  WIDTH  register value.
- Z  out  1  combinational, equals (Q == 0).
- C  out  1  registered carry/borrow/shifted-out bit.
- Busy  out  1  high while a serial shift is in progress.
- Done  out  1  one-cycle pulse when a serial shift completes.

## Operation
FunSel encoding. Each single-cycle operation takes effect at the accepting edge.
- 0000: Q-1. C=1 on borrow (Q was 0), else C=0.
- 0001: Q+1. C=1 on carry (Q was all-ones), else C=0.
- 0010: Q<=I. C unchanged.
- 0011: Q<=0. C<=0.
- 0100: Q<=zero-extended I[7:0].
- 0101: lane ByteSel <= I[7:0]; the other lanes hold. A ByteSel value at or above LANES is a no-op.
- 0110: Q<=sign-extended I[7:0].
- 0111: hold.
- 1000: LSL by 1. C<=Q[W-1].
- 1001: LSR by 1. C<=Q[0].
- 1010: ASR by 1. C<=Q[0].
- 1011: ROL by 1. C<=Q[W-1].
- 1100: ROR by 1. C<=Q[0].
- 1101: serial LSL by ShAmt.
- 1110: serial LSR by ShAmt.
- 1111: reserved; treated as hold.

Flag rules:
- C is unchanged by any FunSel not listed with a C effect above.

Serial shift FSM. States are IDLE and SHIFT.
- In IDLE, accepting 1101/1110 loads the counter with min(ShAmt, WIDTH) and latches the direction.
  - If the count is nonzero, go to SHIFT and set Busy=1.
  - If the count is 0, stay in IDLE and pulse Done on the next cycle; Q and C are unchanged.
- In SHIFT, each edge shifts Q by one bit in the latched direction, sets C to the bit shifted out, and decrements the counter.
- On the edge where the counter reaches 0: return to IDLE, set Busy=0, and pulse Done=1 for exactly one cycle.
- While Busy=1, E, FunSel, I, ByteSel and ShAmt are ignored.
- If ShAmt is at or above WIDTH, the result is Q=0 after WIDTH shifts. C then holds the last bit shifted out.

Reset:
- Asserting Reset=0 at any time, including mid-shift, forces Q=0, C=0, Busy=0, Done=0, state IDLE and counter 0, without waiting for a clock edge.

## Timing
- Reset values: Q=0, Z=1, C=0, Busy=0, Done=0.
- Single-cycle operations: Q and C are valid after the accepting edge. Latency is 1 cycle. One operation can be accepted per cycle.
- Serial shift of N (1≤N≤WIDTH) accepted at edge t0:
  - Busy is high after t0.
  - Shifts happen at edges t1..tN.
  - Busy drops and Done is high after tN, and Done clears after tN+1.
  - The earliest next accept is at tN+1.
- Serial shift of N=0 accepted at t0: Done is high for the single cycle after t0; Busy never rises.
- Z is purely combinational from Q. It adds no latency.

## Configuration
- GENERAL_REGISTER_SAT_EN. When defined, increment and decrement saturate:
  - 0001 at all-ones keeps Q=all-ones and sets C=1.
  - 0000 at 0 keeps Q=0 and sets C=1.
  - All other cases behave as without the macro.
- Without GENERAL_REGISTER_SAT_EN, increment and decrement wrap modulo 2^WIDTH, with C as specified above.

## Test plan
- Reset=0 mid-serial-shift (Q=16'h00F0, ShAmt=4, after 2 shifts) -> immediately Q=0, C=0, Busy=0, Done=0, Z=1.
- WIDTH=16, Q=16'hFFFF, FunSel=0001 -> Q=16'h0000, C=1, Z=1. With GENERAL_REGISTER_SAT_EN defined -> Q=16'hFFFF, C=1.
- WIDTH=32, Q=32'h11223344, FunSel=0101, ByteSel=2, I[7:0]=8'hAB -> Q=32'h11AB3344. Then FunSel=0110 with I[7:0]=8'h80 -> Q=32'hFFFFFF80.
- Q=16'h8001, FunSel=1011 -> Q=16'h0003, C=1. Then FunSel=1010 -> Q=16'h0001, C=1.
- Q=16'h0F0F, FunSel=1101, ShAmt=4 -> Busy high for 4 cycles; a FunSel=0011 issued during Busy is ignored; then Q=16'hF0F0, C=0, one Done pulse.
- Serial LSR with ShAmt=0 -> Q unchanged, one Done pulse, Busy stays 0. Serial LSR with ShAmt=17 on WIDTH=16, Q=16'h8000 -> Q=0, C=1, Done after 16 shifts.
